// File: rtl/noc_route_split.sv
// Routes the merged flit stream via a DEPTH-entry FIFO to one of two ports selected by
// flit[DEST_BIT]. One cycle from accept to valid; a stalled head blocks all ports; in_ready drops only when the FIFO is full.
module noc_route_split #(
   parameter int W        = 9,
   parameter int DEST_BIT = 8,
   parameter int DEPTH    = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [W-1:0]     in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [W-1:0]     out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [W-1:0]     out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

   logic [W-1:0]     mem_q [DEPTH];
   logic [W-1:0]     mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      occ_q, occ_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;

   logic         not_empty;
   logic         full;
   logic         push;
   logic         pop;
   logic         sel;
   logic [W-1:0] head;

   assign not_empty = (occ_q != '0);
   assign full      = (occ_q == FULL_OCC);
   assign head      = mem_q[rd_ptr_q];
   assign sel       = head[DEST_BIT];

   // Ready depends only on stored occupancy, so downstream ready never reaches upstream.
   assign in_ready  = rst_n & ~full;
   assign push      = in_valid & in_ready;
   assign pop       = not_empty & (sel ? out1_ready : out0_ready);

   assign out0_valid = not_empty & ~sel;
   assign out1_valid = not_empty & sel;
   assign out0_data  = out0_valid ? head : '0;
   assign out1_data  = out1_valid ? head : '0;
   assign cnt0       = cnt0_q;
   assign cnt1       = cnt1_q;
   assign empty      = ~not_empty;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      cnt0_d   = cnt0_q;
      cnt1_d   = cnt1_q;

      if (push) begin
         mem_d[wr_ptr_q] = in_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
         if (sel) begin
            cnt1_d = cnt1_q + CNT_W'(1);
         end else begin
            cnt0_d = cnt0_q + CNT_W'(1);
         end
      end
      case ({push, pop})
         2'b10:   occ_d = occ_q + (AW+1)'(1);
         2'b01:   occ_d = occ_q - (AW+1)'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
         cnt0_q   <= '0;
         cnt1_q   <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
         cnt0_q   <= cnt0_d;
         cnt1_q   <= cnt1_d;
      end
   end

endmodule

// File: tb/tb_noc_route_split.sv
// Directed table-driven bench for noc_route_split, counters narrowed to 4 bits for wrap.
module tb_noc_route_split;

   localparam int W     = 9;
   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic [W-1:0]     in_data;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     out0_data;
   logic             out0_valid;
   logic             out0_ready;
   logic [W-1:0]     out1_data;
   logic             out1_valid;
   logic             out1_ready;
   logic [CNT_W-1:0] cnt0;
   logic [CNT_W-1:0] cnt1;
   logic             empty;

   int n_chk;
   int n_bad;

   noc_route_split #(.W(W), .DEST_BIT(8), .DEPTH(4), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .cnt0       (cnt0),
      .cnt1       (cnt1),
      .empty      (empty)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       iv;
      logic [8:0] d;
      logic       r0;
      logic       r1;
      logic       e_rdy;
      logic       e_v0;
      logic [8:0] e_d0;
      logic       e_v1;
      logic [8:0] e_d1;
      logic [3:0] e_c0;
      logic [3:0] e_c1;
      logic       e_emp;
   } vec_t;

   vec_t tbl [22];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic rdy, input logic v0, input logic [8:0] d0,
                           input logic v1, input logic [8:0] d1, input logic [3:0] c0,
                           input logic [3:0] c1, input logic emp);
      chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
      chk({tag, ".v0"}, 32'(out0_valid), 32'(v0));
      chk({tag, ".d0"}, 32'(out0_data), 32'(d0));
      chk({tag, ".v1"}, 32'(out1_valid), 32'(v1));
      chk({tag, ".d1"}, 32'(out1_data), 32'(d1));
      chk({tag, ".cnt0"}, 32'(cnt0), 32'(c0));
      chk({tag, ".cnt1"}, 32'(cnt1), 32'(c1));
      chk({tag, ".empty"}, 32'(empty), 32'(emp));
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_chk = 0;
      n_bad = 0;
      //            iv  d       r0 r1  rdy v0 d0      v1 d1      c0 c1 emp
      tbl[0]  = '{1, 9'h0A5, 1, 1, 1, 1, 9'h0A5, 0, 9'h000, 0, 0, 0};
      tbl[1]  = '{0, 9'h000, 1, 1, 1, 0, 9'h000, 0, 9'h000, 1, 0, 1};
      tbl[2]  = '{1, 9'h101, 1, 1, 1, 0, 9'h000, 1, 9'h101, 1, 0, 0};
      tbl[3]  = '{1, 9'h002, 1, 1, 1, 1, 9'h002, 0, 9'h000, 1, 1, 0};
      tbl[4]  = '{1, 9'h103, 1, 1, 1, 0, 9'h000, 1, 9'h103, 2, 1, 0};
      tbl[5]  = '{1, 9'h004, 1, 1, 1, 1, 9'h004, 0, 9'h000, 2, 2, 0};
      tbl[6]  = '{0, 9'h000, 1, 1, 1, 0, 9'h000, 0, 9'h000, 3, 2, 1};
      tbl[7]  = '{1, 9'h010, 0, 1, 1, 1, 9'h010, 0, 9'h000, 3, 2, 0};
      tbl[8]  = '{1, 9'h020, 0, 1, 1, 1, 9'h010, 0, 9'h000, 3, 2, 0};
      tbl[9]  = '{1, 9'h030, 0, 1, 1, 1, 9'h010, 0, 9'h000, 3, 2, 0};
      tbl[10] = '{1, 9'h040, 0, 1, 0, 1, 9'h010, 0, 9'h000, 3, 2, 0};
      tbl[11] = '{1, 9'h050, 0, 1, 0, 1, 9'h010, 0, 9'h000, 3, 2, 0};
      tbl[12] = '{1, 9'h050, 1, 1, 1, 1, 9'h020, 0, 9'h000, 4, 2, 0};
      tbl[13] = '{1, 9'h050, 1, 1, 1, 1, 9'h030, 0, 9'h000, 5, 2, 0};
      tbl[14] = '{0, 9'h000, 1, 1, 1, 1, 9'h040, 0, 9'h000, 6, 2, 0};
      tbl[15] = '{0, 9'h000, 1, 1, 1, 1, 9'h050, 0, 9'h000, 7, 2, 0};
      tbl[16] = '{0, 9'h000, 1, 1, 1, 0, 9'h000, 0, 9'h000, 8, 2, 1};
      tbl[17] = '{1, 9'h1FF, 1, 0, 1, 0, 9'h000, 1, 9'h1FF, 8, 2, 0};
      tbl[18] = '{1, 9'h011, 1, 0, 1, 0, 9'h000, 1, 9'h1FF, 8, 2, 0};
      tbl[19] = '{0, 9'h000, 1, 0, 1, 0, 9'h000, 1, 9'h1FF, 8, 2, 0};
      tbl[20] = '{0, 9'h000, 1, 1, 1, 1, 9'h011, 0, 9'h000, 8, 3, 0};
      tbl[21] = '{0, 9'h000, 1, 1, 1, 0, 9'h000, 0, 9'h000, 9, 3, 1};

      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      #12;
      chk_outs("reset", 0, 0, 9'h000, 0, 9'h000, 0, 0, 1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post_reset.in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      for (int i = 0; i < 22; i++) begin
         in_valid   = tbl[i].iv;
         in_data    = tbl[i].d;
         out0_ready = tbl[i].r0;
         out1_ready = tbl[i].r1;
         step();
         chk_outs($sformatf("row%0d", i), tbl[i].e_rdy, tbl[i].e_v0, tbl[i].e_d0, tbl[i].e_v1,
                  tbl[i].e_d1, tbl[i].e_c0, tbl[i].e_c1, tbl[i].e_emp);
      end

      // Counter wrap: 17 flits to port 0 from a clean reset leaves cnt0 at 1.
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #2;
      rst_n    = 1'b1;
      @(negedge clk);
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      for (int i = 0; i < 17; i++) begin
         in_valid = 1'b1;
         in_data  = 9'(i);
         step();
      end
      in_valid = 1'b0;
      step();
      step();
      chk("wrap.cnt0", 32'(cnt0), 32'd1);
      chk("wrap.cnt1", 32'(cnt1), 32'd0);
      chk("wrap.empty", 32'(empty), 32'd1);

      // Async reset with three flits buffered on a stalled port 0.
      out0_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         in_valid = 1'b1;
         in_data  = 9'(i);
         step();
      end
      in_valid = 1'b0;
      chk("pre_arst.v0", 32'(out0_valid), 32'd1);
      chk("pre_arst.d0", 32'(out0_data), 32'h001);
      #2;
      rst_n = 1'b0;
      #1;
      chk_outs("arst", 0, 0, 9'h000, 0, 9'h000, 0, 0, 1);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("post_arst.empty", 32'(empty), 32'd1);
      chk("post_arst.v0", 32'(out0_valid), 32'd0);
      in_valid   = 1'b1;
      in_data    = 9'h055;
      out0_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("new.v0", 32'(out0_valid), 32'd1);
      chk("new.d0", 32'(out0_data), 32'h055);
      chk("new.v1", 32'(out1_valid), 32'd0);
      step();
      chk("new.cnt0", 32'(cnt0), 32'd1);
      chk("new.empty", 32'(empty), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
      $finish;
   end

endmodule
